// File: rtl/store_lane_if.sv
// Handshake bundle for store_lane_ctrl: store request in, memory beat out, error pulse out.
// master = request producer / memory sink, slave = the store controller.
interface store_lane_if #(
  parameter int XLEN = 32
) ();
  localparam int NBYTES = XLEN / 8;

  logic              req_valid;
  logic              req_ready;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [2:0]        req_funct3;
  logic              mem_valid;
  logic              mem_ready;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [NBYTES-1:0] mem_be;
  logic              err_valid;
  logic              err_misalign;

  modport master (
    output req_valid, req_addr, req_wdata, req_funct3, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_be, err_valid, err_misalign
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_funct3, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_be, err_valid, err_misalign
  );
endinterface

// File: rtl/store_lane_ctrl.sv
// Store-path controller: decodes byte enables and lane-shifted data, issues registered memory beats.
// Optional macro STORE_SPLIT_EN: word-crossing stores become two beats instead of a misalign error.
module store_lane_ctrl #(
  parameter int XLEN   = 32,
  parameter int NBYTES = XLEN / 8
) (
  input  logic        clk,
  input  logic        reset_n,
  store_lane_if.slave bus
);
  localparam int OFFW = $clog2(NBYTES);
`ifdef STORE_SPLIT_EN
  localparam int SPAN = 2;
  localparam logic [XLEN-1:0] WORD_STEP = XLEN'(NBYTES);
`else
  localparam int SPAN = 1;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_mem_valid;
  logic [XLEN-1:0]   r_mem_addr;
  logic [XLEN-1:0]   r_mem_wdata;
  logic [NBYTES-1:0] r_mem_be;
  logic              r_err_valid;
  logic              r_err_misalign;
`ifdef STORE_SPLIT_EN
  logic              r_split;
  logic [NBYTES-1:0] r_hi_be;
  logic [XLEN-1:0]   r_hi_wdata;
`else
  logic              w_misalign;
`endif

  logic [OFFW-1:0]        w_off;
  logic [SPAN*NBYTES-1:0] w_base;
  logic [SPAN*NBYTES-1:0] w_mask;
  logic [SPAN*XLEN-1:0]   w_wide;
  logic [SPAN*XLEN-1:0]   w_shifted;
  logic [SPAN*XLEN-1:0]   w_data;
  logic [XLEN-1:0]        w_word_addr;
  logic                   w_illegal;
  logic                   w_last;
  logic                   w_ready;
  logic                   w_accept;

  // Byte-span mask and lane-positioned data; bytes outside the span are forced to zero
  always_comb begin
    w_off  = bus.req_addr[OFFW-1:0];
    w_base = '0;
    w_wide = '0;
    w_data = '0;
    for (int i = 0; i < SPAN*NBYTES; i++) begin
      w_base[i] = (32'(i) < (32'd1 << bus.req_funct3[1:0]));
    end
    w_mask = w_base << w_off;
    w_wide[XLEN-1:0] = bus.req_wdata;
    w_shifted = w_wide << {w_off, 3'b000};
    for (int b = 0; b < SPAN*NBYTES; b++) begin
      if (w_mask[b]) begin
        w_data[8*b +: 8] = w_shifted[8*b +: 8];
      end else begin
        w_data[8*b +: 8] = 8'h00;
      end
    end
  end

  // Width legality and (single-beat build only) natural-alignment check
  always_comb begin
    w_illegal = bus.req_funct3[2] | ((bus.req_funct3[1:0] == 2'b11) && (XLEN == 32));
`ifndef STORE_SPLIT_EN
    w_misalign = 1'b0;
    for (int i = 0; i < OFFW; i++) begin
      if (32'(i) < 32'(bus.req_funct3[1:0])) begin
        w_misalign = w_misalign | w_off[i];
      end else begin
        w_misalign = w_misalign;
      end
    end
`endif
  end

  // Request acceptance: idle, or the final beat retires this cycle
  always_comb begin
`ifdef STORE_SPLIT_EN
    w_last = (r_state == ST_BEAT1) || ((r_state == ST_BEAT0) && !r_split);
`else
    w_last = (r_state == ST_BEAT0);
`endif
    w_ready     = (r_state == ST_IDLE) || (w_last && r_mem_valid && bus.mem_ready);
    w_accept    = bus.req_valid && w_ready;
    w_word_addr = {bus.req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
  end

  // Beat sequencer with registered beat and error outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_mem_valid    <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_mem_be       <= '0;
      r_err_valid    <= 1'b0;
      r_err_misalign <= 1'b0;
`ifdef STORE_SPLIT_EN
      r_split        <= 1'b0;
      r_hi_be        <= '0;
      r_hi_wdata     <= '0;
`endif
    end else begin
      r_err_valid    <= 1'b0;
      r_err_misalign <= 1'b0;
`ifdef STORE_SPLIT_EN
      if ((r_state == ST_BEAT0) && r_split && bus.mem_ready) begin
        r_state     <= ST_BEAT1;
        r_split     <= 1'b0;
        r_mem_addr  <= r_mem_addr + WORD_STEP;
        r_mem_be    <= r_hi_be;
        r_mem_wdata <= r_hi_wdata;
      end else
`endif
      if (w_accept) begin
        if (w_illegal) begin
          r_err_valid    <= 1'b1;
          r_err_misalign <= 1'b0;
          r_state        <= ST_IDLE;
          r_mem_valid    <= 1'b0;
          r_mem_addr     <= '0;
          r_mem_wdata    <= '0;
          r_mem_be       <= '0;
`ifndef STORE_SPLIT_EN
        end else if (w_misalign) begin
          r_err_valid    <= 1'b1;
          r_err_misalign <= 1'b1;
          r_state        <= ST_IDLE;
          r_mem_valid    <= 1'b0;
          r_mem_addr     <= '0;
          r_mem_wdata    <= '0;
          r_mem_be       <= '0;
`endif
        end else begin
          r_state     <= ST_BEAT0;
          r_mem_valid <= 1'b1;
          r_mem_addr  <= w_word_addr;
          r_mem_be    <= w_mask[NBYTES-1:0];
          r_mem_wdata <= w_data[XLEN-1:0];
`ifdef STORE_SPLIT_EN
          r_split     <= |w_mask[2*NBYTES-1:NBYTES];
          r_hi_be     <= w_mask[2*NBYTES-1:NBYTES];
          r_hi_wdata  <= w_data[2*XLEN-1:XLEN];
`endif
        end
      end else if (r_mem_valid && bus.mem_ready) begin
        r_state     <= ST_IDLE;
        r_mem_valid <= 1'b0;
        r_mem_addr  <= '0;
        r_mem_wdata <= '0;
        r_mem_be    <= '0;
      end else begin
        r_state <= r_state;
      end
    end
  end

  assign bus.req_ready    = w_ready;
  assign bus.mem_valid    = r_mem_valid;
  assign bus.mem_addr     = r_mem_addr;
  assign bus.mem_wdata    = r_mem_wdata;
  assign bus.mem_be       = r_mem_be;
  assign bus.err_valid    = r_err_valid;
  assign bus.err_misalign = r_err_misalign;
endmodule
